// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired control sequencer for a fetch/decode/execute datapath
//
// Ports:
//   Clock, clear        : system clock; synchronous active-high reset
//   IR[31:0]            : instruction register (opcode=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15])
//   mem_ready           : memory read data valid (only looked at in T1)
//   Stop                : request halt once the current instruction completes
//   PCout..Yin          : single-bit datapath strobes
//   Rin[15:0], Rout[15:0] : one-hot register write / drive enables
//   opcode[4:0]         : ALU operation select (non-zero only in T4)
//   Run                 : high in every state except HALT

module control_sequencer (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    input  logic        Stop,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  opcode,
    output logic        Run
);

    localparam logic [2:0] T0   = 3'd0;
    localparam logic [2:0] T1   = 3'd1;
    localparam logic [2:0] T2   = 3'd2;
    localparam logic [2:0] T3   = 3'd3;
    localparam logic [2:0] T4   = 3'd4;
    localparam logic [2:0] T5   = 3'd5;
    localparam logic [2:0] HALT = 3'd6;

    localparam logic [4:0] OP_HALT = 5'b11011;

    logic [2:0] state;
    logic [2:0] state_next;
    logic [2:0] end_state;
    logic       stop_pending;
    logic       stop_seen;
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       is_alu;
    logic       unused_ir;

    assign op = IR[31:27];
    assign ra = IR[26:23];
    assign rb = IR[22:19];
    assign rc = IR[18:15];
    assign unused_ir = ^IR[14:0];

    // ALU opcodes form the contiguous range 00011..01011
    assign is_alu = (op >= 5'b00011) && (op <= 5'b01011);

    // A Stop seen in the same cycle as the closing transition also counts
    assign stop_seen = stop_pending | Stop;
    assign end_state = stop_seen ? HALT : T0;

    always_comb begin
        state_next = state;
        case (state)
            T0:      state_next = T1;
            T1:      state_next = mem_ready ? T2 : T1;
            T2:      state_next = T3;
            T3: begin
                if (is_alu)
                    state_next = T4;
                else if (op == OP_HALT)
                    state_next = HALT;
                else
                    state_next = end_state;
            end
            T4:      state_next = T5;
            T5:      state_next = end_state;
            HALT:    state_next = HALT;
            default: state_next = T0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            state        <= T0;
            stop_pending <= 1'b0;
        end else begin
            state        <= state_next;
            stop_pending <= stop_seen;
        end
    end

    always_comb begin
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        PCin    = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Rin     = 16'h0000;
        Rout    = 16'h0000;
        opcode  = 5'b00000;
        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                // Read stays up through the stall; the PC/MDR loads fire only with data
                Read = 1'b1;
                if (mem_ready) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                    MDRin   = 1'b1;
                end
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_alu) begin
                    Rout = 16'h0001 << rb;
                    Yin  = 1'b1;
                end
            end
            T4: begin
                Rout   = 16'h0001 << rc;
                Zin    = 1'b1;
                opcode = op;
            end
            T5: begin
                Zlowout = 1'b1;
                Rin     = 16'h0001 << ra;
            end
            default: ;
        endcase
    end

    assign Run = (state != HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer

module tb_control_sequencer;

    logic        Clock;
    logic        clear;
    logic [31:0] IR;
    logic        mem_ready;
    logic        Stop;
    logic        PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  opcode;
    logic        Run;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR(IR), .mem_ready(mem_ready), .Stop(Stop),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
        .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Rin(Rin), .Rout(Rout), .opcode(opcode), .Run(Run)
    );

    // strobe vector: {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin}
    wire [10:0] strobes = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin};

    localparam logic [10:0] S_PCOUT = 11'h400, S_MARIN = 11'h200, S_INCPC = 11'h100, S_ZIN = 11'h080;
    localparam logic [10:0] S_ZLOW  = 11'h040, S_PCIN  = 11'h020, S_READ  = 11'h010, S_MDRIN = 11'h008;
    localparam logic [10:0] S_MDROUT = 11'h004, S_IRIN = 11'h002, S_YIN   = 11'h001;

    typedef struct packed {
        logic [10:0] stb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  opc;
        logic        run;
    } outs_t;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    // Model: position within the instruction (0..5), halted flag, pending stop
    int m_step = 0;
    bit m_halt = 0;
    bit m_stop = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit alu_op(input logic [4:0] op);
        return (op >= 5'd3) && (op <= 5'd11);
    endfunction

    function automatic outs_t expect_outs(input int step, input bit halted,
                                          input logic [31:0] ir, input bit mr);
        outs_t o;
        logic [4:0] op;
        o = '0;
        op = ir[31:27];
        o.run = !halted;
        if (!halted) begin
            case (step)
                0: o.stb = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
                1: o.stb = mr ? (S_READ | S_ZLOW | S_PCIN | S_MDRIN) : S_READ;
                2: o.stb = S_MDROUT | S_IRIN;
                3: if (alu_op(op)) begin
                       o.stb  = S_YIN;
                       o.rout = 16'(1 << ir[22:19]);
                   end
                4: begin
                       o.stb  = S_ZIN;
                       o.rout = 16'(1 << ir[18:15]);
                       o.opc  = op;
                   end
                5: begin
                       o.stb = S_ZLOW;
                       o.rin = 16'(1 << ir[26:23]);
                   end
                default: ;
            endcase
        end
        return o;
    endfunction

    always @(posedge Clock) begin
        if (clear) begin
            m_step = 0;
            m_halt = 0;
            m_stop = 0;
        end else if (!m_halt) begin
            bit done;
            done = 0;
            m_stop = m_stop | Stop;
            case (m_step)
                0: m_step = 1;
                1: if (mem_ready) m_step = 2;
                2: m_step = 3;
                3: begin
                       if (alu_op(IR[31:27])) m_step = 4;
                       else if (IR[31:27] == 5'b11011) m_halt = 1;
                       else done = 1;
                   end
                4: m_step = 5;
                default: done = 1;
            endcase
            if (done) begin
                m_step = 0;
                if (m_stop) m_halt = 1;
            end
        end
    end

    always @(negedge Clock) begin
        if (check_en) begin
            outs_t e;
            e = expect_outs(m_step, m_halt, IR, mem_ready);
            cmp("model_strobes", 32'(strobes), 32'(e.stb));
            cmp("model_rin", 32'(Rin), 32'(e.rin));
            cmp("model_rout", 32'(Rout), 32'(e.rout));
            cmp("model_opcode", 32'(opcode), 32'(e.opc));
            cmp("model_run", 32'(Run), 32'(e.run));
            cmp("rin_onehot", 32'($countones(Rin) <= 1), 32'd1);
            cmp("rout_onehot", 32'($countones(Rout) <= 1), 32'd1);
        end
    end

    task automatic adv();
        @(posedge Clock);
        #1;
    endtask

    task automatic advn(input int n);
        for (int k = 0; k < n; k++) adv();
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        logic [4:0]  op;
        int          sel;
        r   = $urandom();
        sel = $urandom_range(0, 9);
        if (sel < 6)       op = 5'(3 + $urandom_range(0, 8));
        else if (sel == 6) op = 5'b11010;
        else if (sel == 7) op = 5'b11011;
        else               op = 5'($urandom_range(0, 31));
        return {op, r[26:0]};
    endfunction

    initial begin
        clear = 1'b1;
        mem_ready = 1'b1;
        Stop = 1'b0;
        IR = 32'h1891_8000;

        // reset and add R1,R2,R3
        adv();
        check_en = 1;
        #1;
        cmp("reset_t0_strobes", 32'(strobes), 32'h780);
        cmp("reset_run", 32'(Run), 32'd1);
        cmp("reset_rin_rout", {Rin, Rout}, 32'd0);
        cmp("reset_opcode", 32'(opcode), 32'd0);
        clear = 1'b0;
        adv(); cmp("add_t1_strobes", 32'(strobes), 32'h078);
        adv(); cmp("add_t2_strobes", 32'(strobes), 32'h006);
        adv(); cmp("add_t3_rout", 32'(Rout), 32'h0004);
               cmp("add_t3_strobes", 32'(strobes), 32'h001);
        adv(); cmp("add_t4_rout", 32'(Rout), 32'h0008);
               cmp("add_t4_opcode", 32'(opcode), 32'h03);
               cmp("add_t4_strobes", 32'(strobes), 32'h080);
        adv(); cmp("add_t5_rin", 32'(Rin), 32'h0002);
               cmp("add_t5_strobes", 32'(strobes), 32'h040);
        adv(); cmp("add_back_t0", 32'(strobes), 32'h780);

        // or R1,R2,R3
        IR = 32'h5891_8000;
        advn(4);
        cmp("or_t4_opcode", 32'(opcode), 32'h0B);
        cmp("or_t4_rout", 32'(Rout), 32'h0008);
        cmp("or_t4_strobes", 32'(strobes), 32'h080);
        advn(2);

        // three-cycle memory stall in T1
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            adv();
            cmp("stall_t1_strobes", 32'(strobes), 32'h010);
        end
        adv();
        mem_ready = 1'b1;
        #1;
        cmp("stall_release_strobes", 32'(strobes), 32'h078);
        adv(); cmp("stall_then_t2", 32'(strobes), 32'h006);
        advn(4);

        // Stop pulsed in T3 of add
        IR = 32'h1891_8000;
        advn(3);
        Stop = 1'b1;
        adv(); Stop = 1'b0;
        cmp("stop_t4_strobes", 32'(strobes), 32'h080);
        adv(); cmp("stop_t5_rin", 32'(Rin), 32'h0002);
        adv(); cmp("stop_halt_run", 32'(Run), 32'd0);
               cmp("stop_halt_strobes", 32'(strobes), 32'h000);
        advn(3);
        cmp("halt_held_run", 32'(Run), 32'd0);
        clear = 1'b1;
        adv(); clear = 1'b0;
        cmp("halt_clear_t0", 32'(strobes), 32'h780);
        cmp("halt_clear_run", 32'(Run), 32'd1);

        // NOP then HALT opcode
        IR = 32'hD000_0000;
        advn(3);
        cmp("nop_t3_strobes", {21'd0, strobes}, 32'd0);
        cmp("nop_t3_rout", 32'(Rout), 32'd0);
        adv(); cmp("nop_back_t0", 32'(strobes), 32'h780);
        IR = 32'hD800_0000;
        advn(4);
        cmp("haltop_run", 32'(Run), 32'd0);
        clear = 1'b1;
        adv(); clear = 1'b0;

        // clear during T4
        IR = 32'h1891_8000;
        advn(4);
        clear = 1'b1;
        adv(); clear = 1'b0;
        cmp("clear_t4_t0", 32'(strobes), 32'h780);
        cmp("clear_t4_rin", 32'(Rin), 32'd0);
        adv(); cmp("clear_t4_no_rin", 32'(Rin), 32'd0);

        // clear and Stop together: clear wins, no pending stop
        advn(2);
        clear = 1'b1;
        Stop = 1'b1;
        adv(); clear = 1'b0; Stop = 1'b0;
        advn(6);
        cmp("clear_beats_stop_run", 32'(Run), 32'd1);

        // randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            adv();
            clear = ($urandom_range(0, 79) == 0) || (m_halt && $urandom_range(0, 7) == 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            Stop = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) IR = rand_ir();
        end

        adv();
        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
